uart_rx_fifo: RTL

SoC-side UART receiver that consumes the serial stream produced by the testbench UART model's transmitter on the line it drives (idle-high, 8N1, LSB first). It oversamples the line with a per-bit clock counter, validates start and stop bits, and buffers received bytes in a small first-word-fall-through FIFO. A valid/ready port presents the bytes to the user-project logic. Sticky framing and overrun flags report line errors.

---
 rtl/uart_rx_fifo.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with first-word-fall-through byte FIFO
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 347,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr
);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            rx_meta;
    logic            rx_s;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    logic            stop_hit;
    logic            pop;
    logic            push;
    logic            full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A pop in the same cycle as a full-FIFO stop sample frees the slot for the new byte.
    assign stop_hit = (state == STOP) && (cnt == CNT_FULL);
    assign full     = (count == LVL_FULL);
    assign pop      = rx_valid && rx_ready;
    assign push     = stop_hit && rx_s && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (stop_hit && !rx_s)
                frame_err <= 1'b1;
            else if (err_clr)
                frame_err <= 1'b0;
            if (stop_hit && rx_s && full && !pop)
                overrun <= 1'b1;
            else if (err_clr)
                overrun <= 1'b0;
        end
    end

    assign rx_valid = (count != '0);
    assign rx_level = count;
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
    assign busy     = (state != IDLE);
endmodule
